multicycle_controller: RTL

- Control FSM that sequences the shared datapath of the multi-cycle CPU: instruction fetch, decode, execute, memory and writeback.
- Takes the opcode field, instruction[31:26], from the instruction decoder and the ALU zero flag.
- Drives the mux selects, write enables and the memory request handshake.
- One instruction is in flight at a time; there is no pipelining.

---
 rtl/mctrl_pkg.sv | 118 +++++++++++
 rtl/mctrl_perf_counters.sv | 31 +++
 rtl/multicycle_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller: opcodes, FSM state
// encoding, datapath select encodings and the state-only output decode.
package mctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

   localparam logic [1:0] ALUB_REG     = 2'd0;
   localparam logic [1:0] ALUB_FOUR    = 2'd1;
   localparam logic [1:0] ALUB_IMM     = 2'd2;
   localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      MEM_ADDR = 4'd4,
      MEM_RD   = 4'd5,
      MEM_WR   = 4'd6,
      WB_R     = 4'd7,
      WB_I     = 4'd8,
      WB_MEM   = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      HALT     = 4'd12
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       halted;
   } ctrl_t;

   // Outputs that depend on the state alone; ack/zero-qualified strobes are added in the top.
   function automatic ctrl_t moore_decode(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_req = 1'b1;
         end
         DECODE: begin
            c.alu_src_b = ALUB_IMM_SH2;
            c.alu_op    = ALU_ADD;
         end
         EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = ALUB_REG;
            c.alu_op    = ALU_FUNCT;
         end
         EXEC_I, MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = ALUB_IMM;
            c.alu_op    = ALU_ADD;
         end
         MEM_RD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         MEM_WR: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
            c.mem_we  = 1'b1;
         end
         WB_R: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         WB_I: begin
            c.reg_write = 1'b1;
         end
         WB_MEM: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = ALUB_REG;
            c.alu_op    = ALU_SUB;
            c.pc_src    = PC_SRC_BRANCH;
         end
         JUMP: begin
            c.pc_src   = PC_SRC_JUMP;
            c.pc_write = 1'b1;
         end
         HALT: begin
            c.halted = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mctrl_perf_counters.sv
// Free-running cycle and retired-fetch counters for the controller, present
// only in builds with MCTRL_PERF_EN defined.
module mctrl_perf_counters #(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cycle_en_i,
   input  logic                 instr_en_i,
   output logic [CNT_WIDTH-1:0] cycle_count_o,
   output logic [CNT_WIDTH-1:0] instr_count_o
);

   logic [CNT_WIDTH-1:0] cycle_q;
   logic [CNT_WIDTH-1:0] instr_q;

   // Both counters wrap naturally at 2^CNT_WIDTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         if (cycle_en_i) cycle_q <= cycle_q + CNT_WIDTH'(1);
         if (instr_en_i) instr_q <= instr_q + CNT_WIDTH'(1);
      end
   end

   assign cycle_count_o = cycle_q;
   assign instr_count_o = instr_q;

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle CPU datapath (fetch/decode/exec/mem/wb).
// Optional performance counters are built when MCTRL_PERF_EN is defined.
module multicycle_controller
   import mctrl_pkg::*;
#(
   parameter bit ILLEGAL_HALT = 1'b1
`ifdef MCTRL_PERF_EN
   ,
   parameter int unsigned CNT_WIDTH = 32
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       halted,
   output logic       illegal,
   output logic [3:0] state
`ifdef MCTRL_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instr_count
`endif
);

   state_t state_q, state_d;
   ctrl_t  moore_q;
   ctrl_t  ctrl;
   logic   illegal_q, illegal_d;

   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
      case (state_q)
         FETCH:    if (mem_ack) state_d = DECODE;
         DECODE: begin
            case (opcode)
               OP_RTYPE:     state_d = EXEC_R;
               OP_ADDI:      state_d = EXEC_I;
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               OP_HALT:      state_d = HALT;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = ILLEGAL_HALT ? HALT : FETCH;
               end
            endcase
         end
         EXEC_R:   state_d = WB_R;
         EXEC_I:   state_d = WB_I;
         MEM_ADDR: state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
         MEM_RD:   if (mem_ack) state_d = WB_MEM;
         MEM_WR:   if (mem_ack) state_d = FETCH;
         WB_R, WB_I, WB_MEM, BRANCH, JUMP: state_d = FETCH;
         HALT: begin
            state_d   = HALT;
            illegal_d = illegal_q;
         end
         default:  state_d = FETCH;
      endcase
   end

   // State-only outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         moore_q   <= moore_decode(FETCH);
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         moore_q   <= moore_decode(state_d);
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      ctrl = moore_q;
      if (state_q == FETCH && mem_ack) begin
         ctrl.ir_write  = 1'b1;
         ctrl.pc_write  = 1'b1;
         ctrl.pc_src    = PC_SRC_ALU;
         ctrl.alu_src_a = 1'b0;
         ctrl.alu_src_b = ALUB_FOUR;
         ctrl.alu_op    = ALU_ADD;
      end
      if (state_q == BRANCH) ctrl.pc_write = zero;
      // Reset silences everything, including a request that was mid-handshake.
      if (reset) ctrl = '0;
   end

   assign mem_req    = ctrl.mem_req;
   assign mem_we     = ctrl.mem_we;
   assign iord       = ctrl.iord;
   assign ir_write   = ctrl.ir_write;
   assign pc_write   = ctrl.pc_write;
   assign pc_src     = ctrl.pc_src;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign reg_write  = ctrl.reg_write;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign halted     = ctrl.halted;
   assign illegal    = illegal_q & ~reset;
   assign state      = reset ? 4'd0 : state_q;

`ifdef MCTRL_PERF_EN
   mctrl_perf_counters #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_perf (
      .clk           (clk),
      .reset         (reset),
      .cycle_en_i    (state_q != HALT),
      .instr_en_i    (ctrl.ir_write),
      .cycle_count_o (cycle_count),
      .instr_count_o (instr_count)
   );
`endif

endmodule
